// File: rtl/adc_axis_decimator_if.sv
// 16-bit AXI-Stream style link used on both sides of the ADC decimator.
interface adc_axis_decimator_if;
    logic [15:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/adc_axis_decimator.sv
// Averages DECIM ADC samples into one signed sample, never stalls the ADC,
// drops results the sink cannot take and marks every FRAME_LEN-th delivered sample.
module adc_axis_decimator #(
    parameter int DECIM         = 4,
    parameter int OFFSET_BINARY = 1,
    parameter int FRAME_LEN     = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    adc_axis_decimator_if.slave  s_axis,
    adc_axis_decimator_if.master m_axis,
    output logic [15:0]          drop_cnt
);
    localparam int SHIFT  = $clog2(DECIM);
    localparam int ACC_W  = 16 + SHIFT;
    localparam int CNT_W  = (SHIFT > 0) ? SHIFT : 1;
    localparam int FCNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [15:0]       FMT_MASK  = (OFFSET_BINARY != 0) ? 16'h8000 : 16'h0000;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DECIM - 1);
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FRAME_LEN - 1);

    logic                    tready_q;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [FCNT_W-1:0]       fcnt_q, fcnt_d;
    logic [15:0]             tdata_q, tdata_d;
    logic                    tvalid_q, tvalid_d;
    logic                    tlast_q, tlast_d;
    logic [15:0]             drop_q, drop_d;

    logic                    accept, done, hs, load, drop;
    logic signed [15:0]      x;
    logic signed [ACC_W-1:0] sum;
    logic [15:0]             result;

    assign accept = s_axis.tvalid && tready_q;
    assign x      = $signed(s_axis.tdata ^ FMT_MASK);
    assign sum    = acc_q + ACC_W'(x);
    // Arithmetic shift floors the average; the accumulator is wide enough that it never wraps.
    assign result = 16'(sum >>> SHIFT);
    assign done   = accept && (cnt_q == CNT_LAST);
    assign hs     = tvalid_q && m_axis.tready;
    assign load   = done && (!tvalid_q || hs);
    assign drop   = done && tvalid_q && !m_axis.tready;

    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        fcnt_d   = fcnt_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        drop_d   = drop_q;

        if (accept) begin
            if (done) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        if (hs)
            fcnt_d = (fcnt_q == FCNT_LAST) ? '0 : fcnt_q + FCNT_W'(1);

        // tlast follows the frame slot the newly loaded sample will occupy.
        if (load) begin
            tdata_d  = result;
            tvalid_d = 1'b1;
            tlast_d  = (fcnt_d == FCNT_LAST);
        end else if (hs) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
        end

        if (drop && (drop_q != 16'hFFFF))
            drop_d = drop_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tready_q <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            fcnt_q   <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            drop_q   <= '0;
        end else begin
            tready_q <= 1'b1;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            fcnt_q   <= fcnt_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            drop_q   <= drop_d;
        end
    end

    assign s_axis.tready = tready_q;
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;
    assign drop_cnt      = drop_q;
endmodule

// File: tb/tb_adc_axis_decimator.sv
// Directed vectors on DECIM=4 / DECIM=1 instances plus a randomized run of a
// DECIM=8 two's-complement instance against a queue-based reference model.
module tb_adc_axis_decimator;
    localparam int D8 = 8;
    localparam int F8 = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] drop4, drop1, drop8;

    adc_axis_decimator_if s4 ();
    adc_axis_decimator_if m4 ();
    adc_axis_decimator_if s1 ();
    adc_axis_decimator_if m1 ();
    adc_axis_decimator_if s8 ();
    adc_axis_decimator_if m8 ();

    adc_axis_decimator #(.DECIM(4), .OFFSET_BINARY(1), .FRAME_LEN(256)) u4 (
        .clk(clk), .rst(rst), .s_axis(s4), .m_axis(m4), .drop_cnt(drop4));
    adc_axis_decimator #(.DECIM(1), .OFFSET_BINARY(1), .FRAME_LEN(4)) u1 (
        .clk(clk), .rst(rst), .s_axis(s1), .m_axis(m1), .drop_cnt(drop1));
    adc_axis_decimator #(.DECIM(D8), .OFFSET_BINARY(0), .FRAME_LEN(F8)) u8 (
        .clk(clk), .rst(rst), .s_axis(s8), .m_axis(m8), .drop_cnt(drop8));

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk8   = 1'b0;

    typedef struct {
        string       name;
        logic [15:0] s [4];
        logic [15:0] exp;
    } vec_t;
    vec_t vecs [5];

    // Reference model state for the DECIM=8 instance
    int          mq [$];
    bit          mv, ml, mrdy;
    logic [15:0] md;
    int          fc, mdrop;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model8_step();
        bit          hs, done;
        int          sum, avg;
        logic signed [15:0] t;
        if (rst) begin
            mq.delete();
            mv = 0; ml = 0; md = '0; fc = 0; mdrop = 0; mrdy = 0;
        end else begin
            hs   = mv && m8.tready;
            done = 0;
            avg  = 0;
            if (s8.tvalid && mrdy) begin
                t = s8.tdata;
                mq.push_back(int'(t));
                if (mq.size() == D8) begin
                    sum = 0;
                    foreach (mq[i]) sum += mq[i];
                    avg = sum / D8;
                    if (avg * D8 > sum) avg--;
                    mq.delete();
                    done = 1;
                end
            end
            if (hs) fc = (fc + 1) % F8;
            if (done && (!mv || hs)) begin
                mv = 1; md = 16'(avg); ml = (fc == F8 - 1);
            end else if (done) begin
                if (mdrop < 65535) mdrop++;
            end else if (hs) begin
                mv = 0; ml = 0;
            end
            mrdy = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model8_step();
        #1;
        if (chk8) begin
            chk("r8_s_tready", 16'(s8.tready), 16'(mrdy));
            chk("r8_tvalid", 16'(m8.tvalid), 16'(mv));
            if (mv) begin
                chk("r8_tdata", m8.tdata, md);
                chk("r8_tlast", 16'(m8.tlast), 16'(ml));
            end
            chk("r8_drop_cnt", drop8, 16'(mdrop));
        end
    endtask

    task automatic set_vec(input int i, input string nm, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] d, input logic [15:0] e);
        vecs[i].name = nm;
        vecs[i].s[0] = a; vecs[i].s[1] = b; vecs[i].s[2] = c; vecs[i].s[3] = d;
        vecs[i].exp  = e;
    endtask

    task automatic feed4(input logic [15:0] d);
        s4.tvalid = 1'b1;
        s4.tdata  = d;
        tick();
    endtask

    initial begin
        logic [15:0] d;

        set_vec(0, "mid_scale",  16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h0000);
        set_vec(1, "full_pos",   16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h7FFF);
        set_vec(2, "full_neg",   16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h8000);
        set_vec(3, "ramp_avg",   16'h8001, 16'h8002, 16'h8003, 16'h8004, 16'h0002);
        set_vec(4, "neg_floor",  16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h8000, 16'hFFFF);

        rst = 1'b1;
        s4.tvalid = 0; s4.tdata = '0; s4.tlast = 0; m4.tready = 1;
        s1.tvalid = 0; s1.tdata = '0; s1.tlast = 0; m1.tready = 1;
        s8.tvalid = 0; s8.tdata = '0; s8.tlast = 0; m8.tready = 1;
        tick();
        tick();
        chk("rst_s_tready", 16'(s4.tready), 16'd0);
        chk("rst_m_tvalid", 16'(m4.tvalid), 16'd0);
        chk("rst_m_tdata",  m4.tdata, 16'd0);
        chk("rst_m_tlast",  16'(m4.tlast), 16'd0);
        chk("rst_drop_cnt", drop4, 16'd0);
        rst = 1'b0;
        tick();
        chk("tready_after_rst", 16'(s4.tready), 16'd1);

        // Table-driven format/average vectors, sink always ready
        for (int v = 0; v < 5; v++) begin
            for (int k = 0; k < 4; k++) begin
                feed4(vecs[v].s[k]);
                if (k == 2) chk({vecs[v].name, "_early_valid"}, 16'(m4.tvalid), 16'd0);
            end
            chk({vecs[v].name, "_valid"}, 16'(m4.tvalid), 16'd1);
            chk({vecs[v].name, "_data"}, m4.tdata, vecs[v].exp);
        end
        s4.tvalid = 0;
        tick();
        chk("table_clear", 16'(m4.tvalid), 16'd0);

        // Backpressure: first result held, second dropped
        m4.tready = 0;
        for (int k = 0; k < 8; k++) begin
            feed4(16'h8004);
            if (k >= 3) begin
                chk("bp_hold_valid", 16'(m4.tvalid), 16'd1);
                chk("bp_hold_data", m4.tdata, 16'h0004);
            end
        end
        chk("bp_drop_cnt", drop4, 16'd1);
        m4.tready = 1;
        for (int k = 0; k < 4; k++) begin
            feed4(16'h8008);
            if (k == 0) chk("bp_release_clear", 16'(m4.tvalid), 16'd0);
        end
        chk("bp_second_valid", 16'(m4.tvalid), 16'd1);
        chk("bp_second_data", m4.tdata, 16'h0008);
        chk("bp_drop_stable", drop4, 16'd1);
        s4.tvalid = 0;
        tick();

        // Reset with a held output and a partial sum in flight
        m4.tready = 0;
        for (int k = 0; k < 4; k++) feed4(16'h8020);
        chk("rm_held_data", m4.tdata, 16'h0020);
        feed4(16'h0000);
        feed4(16'h0000);
        s4.tvalid = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rm_tvalid", 16'(m4.tvalid), 16'd0);
        chk("rm_tdata", m4.tdata, 16'd0);
        chk("rm_tlast", 16'(m4.tlast), 16'd0);
        chk("rm_drop_cnt", drop4, 16'd0);
        chk("rm_s_tready", 16'(s4.tready), 16'd0);
        tick();
        chk("rm_s_tready_back", 16'(s4.tready), 16'd1);
        m4.tready = 1;
        for (int k = 0; k < 4; k++) feed4(16'h8010);
        chk("rm_after_valid", 16'(m4.tvalid), 16'd1);
        chk("rm_after_data", m4.tdata, 16'h0010);
        s4.tvalid = 0;
        tick();

        // DECIM=1 continuous stream with framing, FRAME_LEN=4
        m1.tready = 1;
        for (int k = 1; k <= 10; k++) begin
            d = 16'($urandom);
            s1.tvalid = 1; s1.tdata = d;
            tick();
            chk("pass_valid", 16'(m1.tvalid), 16'd1);
            chk("pass_data", m1.tdata, d ^ 16'h8000);
            chk("pass_tlast", 16'(m1.tlast), 16'(k % 4 == 0));
        end
        chk("pass_no_drops", drop1, 16'd0);
        s1.tvalid = 0;
        tick();
        chk("pass_clear", 16'(m1.tvalid), 16'd0);

        // Stalls between outputs must not shift the frame boundary
        for (int k = 11; k <= 18; k++) begin
            d = 16'($urandom);
            s1.tvalid = 1; s1.tdata = d; m1.tready = 0;
            tick();
            chk("stall_valid", 16'(m1.tvalid), 16'd1);
            chk("stall_data", m1.tdata, d ^ 16'h8000);
            chk("stall_tlast", 16'(m1.tlast), 16'(k % 4 == 0));
            s1.tvalid = 0;
            tick();
            chk("stall_hold_data", m1.tdata, d ^ 16'h8000);
            chk("stall_hold_tlast", 16'(m1.tlast), 16'(k % 4 == 0));
            m1.tready = 1;
            tick();
            chk("stall_clear", 16'(m1.tvalid), 16'd0);
        end

        // Randomized run against the reference model, including a reset pulse
        chk8 = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            s8.tvalid = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0:       s8.tdata = 16'h8000;
                1:       s8.tdata = 16'h7FFF;
                default: s8.tdata = 16'($urandom);
            endcase
            m8.tready = (c < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            rst = (c == 2000);
            tick();
        end
        rst = 1'b0;
        chk8 = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/adc_axis_decimator.md
ADC_AXIS_DECIMATOR -- requirements
Module: adc_axis_decimator

Interface
REQ-001 Parameter DECIM, default 4: samples averaged per output; SHALL be a power of two, 1..64.
REQ-002 Parameter OFFSET_BINARY, default 1: 1 = input is offset binary, 0 = input is two's complement.
REQ-003 Parameter FRAME_LEN, default 256: output samples per tlast frame, 1..65535.
REQ-004 clk  in  1  fabric clock, 100 MHz; all logic on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 s_axis_tdata  in  16  raw ADC sample from the ADC AXIS source.
REQ-007 s_axis_tvalid  in  1  input sample valid.
REQ-008 s_axis_tready  out  1  input ready, registered.
REQ-009 m_axis_tdata  out  16  averaged signed two's-complement sample.
REQ-010 m_axis_tvalid  out  1  output valid.
REQ-011 m_axis_tready  in  1  downstream ready.
REQ-012 m_axis_tlast  out  1  marks the last sample of each FRAME_LEN frame.
REQ-013 drop_cnt  out  16  saturating count of averaged results discarded because the output register was full.

Function
REQ-014 s_axis_tready SHALL be 1 on every cycle not in reset; the block never back-pressures the ADC source.
REQ-015 Accepted sample = cycle with s_axis_tvalid && s_axis_tready.
REQ-016 Input conversion: x = signed(tdata ^ 16'h8000) if OFFSET_BINARY=1, else signed(tdata).
REQ-017 Accumulator width = 16 + log2(DECIM) bits, signed; cannot overflow.
REQ-018 Sample counter cnt runs 0..DECIM-1 and advances on each accepted sample.
REQ-019 On an accepted sample with cnt < DECIM-1: acc <= acc + x, cnt <= cnt + 1.
REQ-020 On an accepted sample with cnt = DECIM-1, the block SHALL complete a result:
- result = (acc + x) arithmetic-shifted right by log2(DECIM), which truncates toward minus infinity.
- acc <= 0, cnt <= 0.
REQ-021 DECIM=1 SHALL act as pass-through with format conversion; every accepted sample completes a result.
REQ-022 Output register: on completion, if m_axis_tvalid=0 or (m_axis_tvalid && m_axis_tready) that cycle, result SHALL load into m_axis_tdata and m_axis_tvalid SHALL be 1 on the next cycle (latency 1 clk from the final accepted sample).
REQ-023 Drop rule: on completion with m_axis_tvalid && !m_axis_tready, the result SHALL be discarded and drop_cnt SHALL increment, saturating at 16'hFFFF; the held output SHALL be unchanged.
REQ-024 Hold rule: while m_axis_tvalid && !m_axis_tready, m_axis_tdata and m_axis_tlast SHALL be stable.
REQ-025 Clear rule: on an output handshake with no simultaneous completion, m_axis_tvalid SHALL go to 0 on the next cycle.
REQ-026 Frame counter fcnt (0..FRAME_LEN-1) SHALL advance on each output handshake and wrap to 0 after FRAME_LEN-1.
REQ-027 m_axis_tlast SHALL be 1 exactly when the held output corresponds to fcnt = FRAME_LEN-1; dropped results SHALL NOT advance fcnt.
REQ-028 A cycle with s_axis_tvalid=0 SHALL leave acc and cnt unchanged.

Reset
REQ-029 While rst=1 at a clock edge:
- s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, drop_cnt=0.
- acc=0, cnt=0, fcnt=0.
REQ-030 Reset mid-accumulation SHALL discard the partial sum.
REQ-031 Reset with m_axis_tvalid=1 SHALL drop the held sample without a handshake.
REQ-032 s_axis_tready SHALL return to 1 on the first clock edge with rst=0.

Verification
REQ-033 Format and average, DECIM=4, OFFSET_BINARY=1, m_axis_tready=1:
- 4x 16'h8000 -> 16'h0000.
- 4x 16'hFFFF -> 16'h7FFF.
- 4x 16'h0000 -> 16'h8000.
- 16'h8001, 16'h8002, 16'h8003, 16'h8004 -> 16'h0002, with tvalid 1 cycle after the 4th sample is accepted.
REQ-034 Negative truncation, DECIM=4: 16'h7FFF x3 then 16'h8000 (sum -3) -> 16'hFFFF.
REQ-035 Backpressure, DECIM=4: m_axis_tready=0 for 8 input samples of 16'h8004 followed by 4 of 16'h8008:
- First result 16'h0004 is held stable.
- Second result is dropped and drop_cnt=1.
- m_axis_tready=1 then yields 16'h0004 followed by 16'h0008.
REQ-036 Simultaneous events, DECIM=1: continuous input with m_axis_tready=1 -> one output per cycle, no drops, tvalid held at 1.
REQ-037 Framing: FRAME_LEN=4, DECIM=1, 10 outputs -> tlast on outputs 4 and 8 only; stalls inserted mid-frame do not move tlast.
REQ-038 Reset mid-operation: rst pulsed after 2 of 4 samples -> all outputs 0 on the next cycle; the next 4 samples of 16'h8010 -> 16'h0010.
